// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream, writes 16-bit words to instruction
// memory and holds the CPU in reset until a checksum-verified image is loaded.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module imem_loader #(
   parameter int ADDR_W         = 10,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   output logic              o_rx_ready,
   output logic              o_imem_we,
   output logic [ADDR_W-1:0] o_imem_addr,
   output logic [15:0]       o_imem_wdata,
   output logic              o_cpu_reset,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_error
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
   } state_t;

   localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

   state_t            r_state, w_state_nxt;
   logic [7:0]        r_len_hi;
   logic [15:0]       r_len;
   logic [7:0]        r_hi;
   logic [7:0]        r_sum;
   logic [ADDR_W:0]   r_cnt;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_wdata;

   logic              w_accept;
   logic              w_clear;
   logic              w_timeout;
   logic [15:0]       w_len_in;
   logic [ADDR_W:0]   w_cnt_nxt;

   assign o_rx_ready = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                       (r_state == S_DATA_HI) || (r_state == S_DATA_LO) ||
                       (r_state == S_CHECK);
   assign o_busy     = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
   assign o_done     = (r_state == S_DONE);
   assign o_error    = (r_state == S_ERROR);
   assign o_cpu_reset = (r_state != S_DONE);

   assign o_imem_we    = r_we;
   assign o_imem_addr  = r_addr;
   assign o_imem_wdata = r_wdata;

   assign w_accept  = i_rx_valid && o_rx_ready;
   assign w_len_in  = {r_len_hi, i_rx_data};
   // counter is one bit wider than the address so N = 2^ADDR_W terminates cleanly
   assign w_cnt_nxt = r_cnt + (ADDR_W+1)'(1);

`ifdef LOADER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] r_tmo;

   assign w_timeout = o_busy && !w_accept && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         r_tmo <= '0;
      else if (w_clear || w_accept || !o_busy)
         r_tmo <= '0;
      else
         r_tmo <= r_tmo + TMO_W'(1);
   end
`else
   logic w_unused_tmo;
   assign w_timeout    = 1'b0;
   assign w_unused_tmo = |32'(TIMEOUT_CYCLES);
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_clear     = 1'b0;
      case (r_state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (i_start) begin
               w_state_nxt = S_LEN_HI;
               w_clear     = 1'b1;
            end
         end
         S_LEN_HI: if (w_accept) w_state_nxt = S_LEN_LO;
         S_LEN_LO: begin
            if (w_accept) begin
               if (w_len_in == 16'd0)
                  w_state_nxt = S_CHECK;
               else if (32'(w_len_in) > MAX_WORDS)
                  w_state_nxt = S_ERROR;
               else
                  w_state_nxt = S_DATA_HI;
            end
         end
         S_DATA_HI: if (w_accept) w_state_nxt = S_DATA_LO;
         S_DATA_LO: begin
            if (w_accept)
               w_state_nxt = (32'(w_cnt_nxt) == 32'(r_len)) ? S_CHECK : S_DATA_HI;
         end
         S_CHECK: begin
            if (w_accept)
               w_state_nxt = (i_rx_data == r_sum) ? S_DONE : S_ERROR;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_timeout)
         w_state_nxt = S_ERROR;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_len_hi <= '0;
         r_len    <= '0;
         r_hi     <= '0;
         r_sum    <= '0;
         r_cnt    <= '0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else begin
         r_we <= 1'b0;
         if (w_clear) begin
            r_sum <= '0;
            r_cnt <= '0;
         end else if (w_accept) begin
            // the CHK byte also lands in r_sum, harmless since the frame ends there
            r_sum <= r_sum + i_rx_data;
            case (r_state)
               S_LEN_HI:  r_len_hi <= i_rx_data;
               S_LEN_LO:  r_len    <= w_len_in;
               S_DATA_HI: r_hi     <= i_rx_data;
               S_DATA_LO: begin
                  r_we    <= 1'b1;
                  r_addr  <= r_cnt[ADDR_W-1:0];
                  r_wdata <= {r_hi, i_rx_data};
                  r_cnt   <= w_cnt_nxt;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random frames against a frame-level model.
// Timeout scenario follows LOADER_TIMEOUT_EN when defined.
module tb_imem_loader;
   localparam int ADDR_W = 10;
   localparam int TMO    = 16;

   typedef logic [7:0] u8_t;
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       data;
   } wr_t;

   logic              i_clk = 1'b0;
   logic              i_reset = 1'b1;
   logic              i_start = 1'b0;
   logic [7:0]        i_rx_data = 8'h00;
   logic              i_rx_valid = 1'b0;
   logic              o_rx_ready, o_imem_we, o_cpu_reset, o_busy, o_done, o_error;
   logic [ADDR_W-1:0] o_imem_addr;
   logic [15:0]       o_imem_wdata;

   wr_t wq[$];
   wr_t exp_wq[$];
   u8_t fr[$];
   int  n_checks = 0;
   int  n_err = 0;
   int  n_adj = 0;
   bit  prev_we = 1'b0;

   imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
      .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
      .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata),
      .o_cpu_reset(o_cpu_reset), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
   );

   always #5 i_clk = ~i_clk;

   // write monitor: collects every strobe and counts strobes on adjacent cycles
   always @(negedge i_clk) begin
      if (o_imem_we) begin
         wq.push_back('{addr: o_imem_addr, data: o_imem_wdata});
         if (prev_we) n_adj++;
      end
      prev_we <= o_imem_we;
   end

   // Reference: parse the frame from its definition, predict writes and outcome.
   task automatic model_frame(input u8_t f[$], output int nb, output bit ok);
      int  len;
      u8_t sum;
      exp_wq.delete();
      len = int'({f[0], f[1]});
      if (len > (1 << ADDR_W)) begin
         nb = 2;
         ok = 1'b0;
         return;
      end
      sum = 8'h00;
      for (int i = 0; i < 2 + 2*len; i++) sum = sum + f[i];
      for (int k = 0; k < len; k++)
         exp_wq.push_back('{addr: ADDR_W'(k), data: {f[2+2*k], f[3+2*k]}});
      ok = (f[2+2*len] == sum);
      nb = 3 + 2*len;
   endtask

   task automatic build_frame(input int n, input bit bad);
      u8_t s, b;
      fr.delete();
      fr.push_back(u8_t'(n >> 8));
      fr.push_back(u8_t'(n));
      s = fr[0] + fr[1];
      for (int i = 0; i < 2*n; i++) begin
         b = u8_t'($urandom);
         fr.push_back(b);
         s = s + b;
      end
      fr.push_back(bad ? (s ^ u8_t'($urandom_range(255, 1))) : s);
   endtask

   task automatic send_byte(input u8_t b, input int gap);
      int w = 0;
      i_rx_valid = 1'b0;
      if (gap > 0) begin
         i_rx_data = u8_t'($urandom);
         repeat (gap) @(posedge i_clk);
         #1;
      end
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      while (!o_rx_ready && w < 50) begin
         @(posedge i_clk); #1;
         w++;
      end
      n_checks++;
      if (!o_rx_ready) begin
         n_err++;
         $display("FAIL accept: byte %02h never accepted, rx_ready=%b want 1", b, o_rx_ready);
         i_rx_valid = 1'b0;
         return;
      end
      @(posedge i_clk); #1;
      i_rx_valid = 1'b0;
   endtask

   // pulses start, reports busy/ready one cycle later, then sends nb bytes
   task automatic load(input int nb, input int gmin, input int gmax, output bit bs);
      wq.delete();
      i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      bs = o_busy && o_rx_ready;
      for (int i = 0; i < nb; i++)
         send_byte(fr[i], (i == 0) ? 0 : int'($urandom_range(gmax, gmin)));
   endtask

   task automatic test_reset();
      n_checks++;
      if ({o_rx_ready, o_imem_we, o_imem_addr, o_imem_wdata, o_cpu_reset, o_busy, o_done, o_error}
          !== {1'b0, 1'b0, {ADDR_W{1'b0}}, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_values: rdy=%b we=%b addr=%0h wd=%0h cpur=%b busy=%b done=%b err=%b want 0 0 0 0 1 0 0 0",
                  o_rx_ready, o_imem_we, o_imem_addr, o_imem_wdata, o_cpu_reset, o_busy, o_done, o_error);
      end
   endtask

   task automatic test_plan_frames();
      int nb; bit ok, bs, mism;
      bit exp_ok[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int t = 0; t < 5; t++) begin
         case (t)
            0, 3: fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
            1:    fr = '{8'h00, 8'h00, 8'h00};
            2:    fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1};
            default: fr = '{8'h04, 8'h01};
         endcase
         model_frame(fr, nb, ok);
         load(nb, 0, 0, bs);
         n_checks++;
         if (!bs) begin
            n_err++;
            $display("FAIL plan%0d start_latency: busy&ready=%b want 1", t, bs);
         end
         mism = (wq.size() != exp_wq.size());
         foreach (exp_wq[k]) if (k < wq.size() && wq[k] !== exp_wq[k]) mism = 1'b1;
         n_checks++;
         if (mism) begin
            n_err++;
            $display("FAIL plan%0d writes: got %0d words (first %0h) want %0d words",
                     t, wq.size(), (wq.size() > 0) ? wq[0] : '0, exp_wq.size());
         end
         n_checks++;
         if ({o_done, o_error, o_cpu_reset, o_busy, o_rx_ready} !== {exp_ok[t], !exp_ok[t], !exp_ok[t], 2'b00}) begin
            n_err++;
            $display("FAIL plan%0d status: done/err/cpur/busy/rdy=%b%b%b%b%b want %b%b%b00",
                     t, o_done, o_error, o_cpu_reset, o_busy, o_rx_ready, exp_ok[t], !exp_ok[t], !exp_ok[t]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int nb; bit ok, bs, mism;
      n_adj = 0;
      for (int t = 0; t < 20; t++) begin
         build_frame(int'($urandom_range(12, 0)), ($urandom_range(3, 0) == 0));
         model_frame(fr, nb, ok);
         load(nb, 0, 0, bs);
         mism = !bs || (wq.size() != exp_wq.size());
         foreach (exp_wq[k]) if (k < wq.size() && wq[k] !== exp_wq[k]) mism = 1'b1;
         n_checks++;
         if (mism || {o_done, o_error, o_cpu_reset, o_busy} !== {ok, !ok, !ok, 1'b0}) begin
            n_err++;
            $display("FAIL b2b%0d: words=%0d want %0d done=%b err=%b cpur=%b busy=%b want ok=%b",
                     t, wq.size(), exp_wq.size(), o_done, o_error, o_cpu_reset, o_busy, ok);
         end
      end
      n_checks++;
      if (n_adj != 0) begin
         n_err++;
         $display("FAIL strobe_spacing: %0d adjacent-cycle strobes want 0", n_adj);
      end
   endtask

   task automatic test_backpressure();
      int nb; bit ok, bs, mism;
      for (int t = 0; t < 8; t++) begin
         if (t == 0) fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
         else build_frame(int'($urandom_range(6, 1)), ($urandom_range(2, 0) == 0));
         model_frame(fr, nb, ok);
         if (t == 0) load(nb, 3, 3, bs);
         else load(nb, 0, 5, bs);
         mism = !bs || (wq.size() != exp_wq.size());
         foreach (exp_wq[k]) if (k < wq.size() && wq[k] !== exp_wq[k]) mism = 1'b1;
         n_checks++;
         if (mism || {o_done, o_error, o_cpu_reset, o_busy} !== {ok, !ok, !ok, 1'b0}) begin
            n_err++;
            $display("FAIL bp%0d: words=%0d want %0d done=%b err=%b cpur=%b busy=%b want ok=%b",
                     t, wq.size(), exp_wq.size(), o_done, o_error, o_cpu_reset, o_busy, ok);
         end
      end
   endtask

   task automatic test_full_image();
      int nb; bit ok, bs, mism;
      build_frame(1 << ADDR_W, 1'b0);
      model_frame(fr, nb, ok);
      load(nb, 0, 0, bs);
      mism = (wq.size() != exp_wq.size());
      foreach (exp_wq[k]) if (k < wq.size() && wq[k] !== exp_wq[k]) mism = 1'b1;
      n_checks++;
      if (mism) begin
         n_err++;
         $display("FAIL full_writes: got %0d words want %0d", wq.size(), exp_wq.size());
      end
      n_checks++;
      if ({o_done, o_error, o_cpu_reset} !== 3'b100) begin
         n_err++;
         $display("FAIL full_status: done/err/cpur=%b%b%b want 100", o_done, o_error, o_cpu_reset);
      end
   endtask

   task automatic test_reset_midload();
      int nb; bit ok, bs;
      fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
      model_frame(fr, nb, ok);
      load(4, 0, 0, bs);
      i_reset = 1'b1;
      #1;
      test_reset();
      repeat (2) @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      i_rx_valid = 1'b1;
      i_rx_data = 8'hAB;
      repeat (10) @(posedge i_clk);
      #1;
      i_rx_valid = 1'b0;
      n_checks++;
      if (wq.size() != 0 || {o_busy, o_cpu_reset, o_done, o_error} !== 4'b0100) begin
         n_err++;
         $display("FAIL reset_midload: writes=%0d busy=%b cpur=%b done=%b err=%b want 0 0 1 0 0",
                  wq.size(), o_busy, o_cpu_reset, o_done, o_error);
      end
   endtask

   task automatic test_timeout();
      bit bs;
      fr = '{8'h00};
      load(1, 0, 0, bs);
`ifdef LOADER_TIMEOUT_EN
      repeat (10) @(posedge i_clk);
      #1;
      n_checks++;
      if (!o_busy || o_error) begin
         n_err++;
         $display("FAIL timeout_early: busy=%b err=%b want 1 0", o_busy, o_error);
      end
      repeat (10) @(posedge i_clk);
      #1;
      n_checks++;
      if ({o_error, o_cpu_reset, o_busy, o_rx_ready} !== 4'b1100) begin
         n_err++;
         $display("FAIL timeout: err/cpur/busy/rdy=%b%b%b%b want 1100", o_error, o_cpu_reset, o_busy, o_rx_ready);
      end
`else
      repeat (100) @(posedge i_clk);
      #1;
      n_checks++;
      if ({o_busy, o_rx_ready, o_error, o_cpu_reset} !== 4'b1101) begin
         n_err++;
         $display("FAIL no_timeout: busy/rdy/err/cpur=%b%b%b%b want 1101", o_busy, o_rx_ready, o_error, o_cpu_reset);
      end
`endif
      i_reset = 1'b1;
      @(posedge i_clk); #1;
      i_reset = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge i_clk);
      #1;
      test_reset();
      i_reset = 1'b0;
      @(posedge i_clk); #1;
      test_plan_frames();
      test_back_to_back();
      test_backpressure();
      test_full_image();
      test_reset_midload();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the single-cycle CPU's instruction memory. It receives a framed byte stream over a valid/ready handshake and assembles 16-bit instruction words. It writes them to consecutive instruction-memory addresses and holds the CPU in reset until a complete, checksum-verified image is in place. It is the writer side of the instruction memory that the CPU reads every cycle, and it replaces preloading the memory from the bench.

## Interface
- ADDR_W, 10, instruction-memory address width; max image = 2^ADDR_W words
- TIMEOUT_CYCLES, 1024, inter-byte timeout; used only with LOADER_TIMEOUT_EN
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load when not busy
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader accepts a byte this cycle
- imem_we  output  1  instruction-memory write strobe, one cycle per word
- imem_addr  output  ADDR_W  word address
- imem_wdata  output  16  instruction word
- cpu_reset  output  1  drives the CPU reset; high until a load completes
- busy  output  1  load in progress
- done  output  1  last load succeeded; sticky until next start or reset
- error  output  1  last load failed; sticky until next start or reset

## Operation
- Frame format: LEN_HI, LEN_LO, then N words as HI byte then LO byte (big-endian), then CHK. N = {LEN_HI, LEN_LO}.
- CHK = 8-bit sum mod 256 of every preceding frame byte, including the length bytes.
- A byte is accepted on a rising edge when rx_valid && rx_ready.
- States and transitions:
  - IDLE: start → LEN_HI.
  - LEN_HI → LEN_LO.
  - LEN_LO: N = 0 → CHECK; N > 2^ADDR_W → ERROR; otherwise → DATA_HI.
  - DATA_HI → DATA_LO.
  - DATA_LO: word count reaches N → CHECK; otherwise → DATA_HI.
  - CHECK: match → DONE; mismatch → ERROR.
  - DONE / ERROR: start → LEN_HI.
- Each transition out of a receiving state fires on that state's byte acceptance.
- rx_ready is high only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK.
- Word k (0-based) is written to imem_addr = k.
- Writes already issued are not rolled back on error.
- cpu_reset is 1 from reset through the entire load, and stays 1 in ERROR. It goes to 0 only in DONE.
- A start that takes the block from DONE to LEN_HI raises cpu_reset again.
- start is ignored while busy.
- busy is 1 in every state other than IDLE, DONE and ERROR.
- Running checksum and word counter clear on start.

## Timing
- Reset values: rx_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_reset 1, busy 0, done 0, error 0. State goes to IDLE.
- Reset asserted mid-load aborts immediately to these values. A new start is required.
- start sampled at edge t: busy = 1 and rx_ready = 1 from t+1.
- LO byte of word k accepted at edge t: imem_we = 1, imem_addr = k, imem_wdata = {HI, LO} during cycle t+1 only. Back-to-back words therefore produce strobes no closer than 2 cycles apart.
- CHK accepted at edge t: from t+1, done or error = 1 and busy = 0. In the success case cpu_reset = 0 from t+1.
- Oversize length: error = 1 and rx_ready = 0 from the cycle after LEN_LO is accepted. No imem_we is issued.
- rx_valid may drop for any number of cycles. State, counters and checksum hold while no byte is accepted.
- Counters are wide enough that N = 2^ADDR_W is legal and fills the memory exactly. Address wrap never occurs.

## Configuration
- LOADER_TIMEOUT_EN defined:
  - A counter runs while busy and clears on each byte acceptance and on start.
  - If it reaches TIMEOUT_CYCLES with no byte accepted, the next cycle is in ERROR: error = 1, busy = 0, rx_ready = 0, cpu_reset stays 1.
- LOADER_TIMEOUT_EN undefined: no counter is built. The loader waits indefinitely in any receiving state.

## Test plan
- Good load, ADDR_W=10: start, then bytes 00 02 12 34 AB CD C0 with rx_valid continuous. Required: writes addr0=0x1234, addr1=0xABCD, each a single-cycle imem_we; done=1 and cpu_reset=0 the cycle after C0 is accepted.
- Empty image: bytes 00 00 00. Required: no imem_we; done=1; cpu_reset=0.
- Bad checksum: bytes 00 02 12 34 AB CD C1. Required: 2 writes occur, then error=1, done=0, cpu_reset stays 1. A following start plus the good frame gives done=1.
- Oversize: bytes 04 01. Required: error=1 the cycle after 01 is accepted, no imem_we, rx_ready=0.
- Backpressure and reset: send the good frame with rx_valid low 3 cycles between each byte. Required: same results as the continuous case. Then assert reset after the 4th byte of a new load. Required: all outputs at reset values, cpu_reset=1, no further writes.
- With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16: start, send 00, then hold rx_valid low. Required: error=1 about 16 cycles after the last acceptance, cpu_reset=1. Without the macro: still busy after 100 cycles.
